// File: rtl/sti_dac_gen.sv
// Parallel-to-serial converter with pixel packer: serialises a framed word on so_data
// and writes each PIX_W-bit group to a pixel memory, zero-filling it once the last word is seen.
module sti_dac_gen #(
    parameter  int DATA_W    = 16,
    parameter  int LEN_W     = 2,
    parameter  int PIX_W     = 8,
    parameter  int PIX_DEPTH = 256,
    localparam int AW        = $clog2(PIX_DEPTH)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] pi_data,
    input  logic [LEN_W-1:0]  pi_length,
    input  logic              pi_fill,
    input  logic              pi_msb,
    input  logic              pi_low,
    input  logic              pi_end,
    output logic              busy,
    output logic              so_data,
    output logic              so_valid,
    output logic              pixel_wr,
    output logic [AW-1:0]     pixel_addr,
    output logic [PIX_W-1:0]  pixel_dataout,
    output logic              pixel_finish,
    output logic              pixel_overflow
);
    localparam int FW  = PIX_W * (2 ** LEN_W);
    localparam int XW  = (FW > DATA_W) ? FW : DATA_W;
    localparam int CW  = LEN_W + $clog2(PIX_W) + 1;
    localparam int PCW = $clog2(PIX_W);
    localparam logic [AW-1:0] ADDR_MAX = AW'(PIX_DEPTH - 1);

    typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_FILL, S_DONE} state_t;
    state_t state, nstate;

    logic [FW-1:0]    shreg;
    logic             msb_r;
    logic [CW-1:0]    bit_cnt;
    logic [PIX_W-2:0] pix_sr;
    logic [PCW-1:0]   pix_cnt;
    logic             end_flag;
    logic [AW-1:0]    waddr;
    logic             full;

    logic [CW-1:0]    len_l;
    int               ln;
    logic [XW-1:0]    ext, frame_x;
    logic [FW-1:0]    frame_f, frame_al;
    logic             cur_bit, px_done, fill_wr;
    logic [PIX_W-1:0] pix_next;

    // Frame is stored pre-aligned so the outgoing bit is always shreg's MSB or LSB.
    always_comb begin
        len_l = CW'(PIX_W) * (CW'(pi_length) + CW'(1));
        ln    = int'(len_l);
        ext   = XW'(pi_data);
        if (ln == DATA_W)
            frame_x = ext;
        else if (ln < DATA_W)
            frame_x = pi_low ? (ext & ({XW{1'b1}} >> (XW - ln))) : (ext >> (DATA_W - ln));
        else
            frame_x = pi_fill ? (ext << (ln - DATA_W)) : ext;
        frame_f  = FW'(frame_x);
        frame_al = pi_msb ? (frame_f << (FW - ln)) : frame_f;
    end

    assign cur_bit  = msb_r ? shreg[FW-1] : shreg[0];
    assign so_valid = (state == S_SHIFT);
    assign so_data  = so_valid & cur_bit;
    assign busy     = (state != S_IDLE);
    assign pixel_finish = (state == S_DONE);
    assign pix_next = {pix_sr, cur_bit};
    assign px_done  = (state == S_SHIFT) && (pix_cnt == PCW'(PIX_W - 1));
    assign fill_wr  = (state == S_FILL) && !full;

    always_comb begin
        nstate = state;
        case (state)
            S_IDLE:  if (load) nstate = S_SHIFT;
                     else if (end_flag) nstate = S_FILL;
            S_SHIFT: if (bit_cnt == CW'(1)) nstate = (end_flag || pi_end) ? S_FILL : S_IDLE;
            S_FILL:  if (full) nstate = S_DONE;
            S_DONE:  nstate = S_DONE;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= S_IDLE;
            shreg          <= '0;
            msb_r          <= 1'b0;
            bit_cnt        <= '0;
            pix_sr         <= '0;
            pix_cnt        <= '0;
            end_flag       <= 1'b0;
            waddr          <= '0;
            full           <= 1'b0;
            pixel_wr       <= 1'b0;
            pixel_addr     <= '0;
            pixel_dataout  <= '0;
            pixel_overflow <= 1'b0;
        end else begin
            state    <= nstate;
            pixel_wr <= 1'b0;
            if (pi_end) end_flag <= 1'b1;
            if (state == S_IDLE && load) begin
                shreg   <= frame_al;
                msb_r   <= pi_msb;
                bit_cnt <= len_l;
                pix_cnt <= '0;
            end
            if (state == S_SHIFT) begin
                shreg   <= msb_r ? (shreg << 1) : (shreg >> 1);
                bit_cnt <= bit_cnt - CW'(1);
                pix_sr  <= pix_next[PIX_W-2:0];
                pix_cnt <= px_done ? '0 : pix_cnt + PCW'(1);
            end
            // pixel_addr shows the target during the write, the next free slot otherwise
            if (px_done || fill_wr) begin
                if (full)
                    pixel_overflow <= 1'b1;
                else begin
                    pixel_wr      <= 1'b1;
                    pixel_addr    <= waddr;
                    pixel_dataout <= fill_wr ? '0 : pix_next;
                    if (waddr == ADDR_MAX) full <= 1'b1;
                    else waddr <= waddr + AW'(1);
                end
            end else
                pixel_addr <= waddr;
        end
    end
endmodule

// File: tb/tb_sti_dac_gen.sv
// Directed bench for sti_dac_gen: vector table for framing/bit order, plus sequences
// for busy-load rejection, end-of-data fill, overflow (depth 4) and mid-word reset.
module tb_sti_dac_gen;
    logic        clk = 0, reset = 1, r4 = 1;
    logic        load = 0, pi_fill = 0, pi_msb = 0, pi_low = 0, pi_end = 0;
    logic [15:0] pi_data = '0;
    logic [1:0]  pi_length = '0;
    logic        busy, so_data, so_valid, pixel_wr, pixel_finish, pixel_overflow;
    logic [7:0]  pixel_addr, pixel_dataout;
    logic        busy4, so_data4, so_valid4, wr4, fin4, ov4;
    logic [1:0]  addr4;
    logic [7:0]  dout4;

    sti_dac_gen dut (
        .clk(clk), .reset(reset), .load(load), .pi_data(pi_data), .pi_length(pi_length),
        .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .busy(busy), .so_data(so_data), .so_valid(so_valid), .pixel_wr(pixel_wr),
        .pixel_addr(pixel_addr), .pixel_dataout(pixel_dataout),
        .pixel_finish(pixel_finish), .pixel_overflow(pixel_overflow));

    sti_dac_gen #(.PIX_DEPTH(4)) dut4 (
        .clk(clk), .reset(r4), .load(load), .pi_data(pi_data), .pi_length(pi_length),
        .pi_fill(pi_fill), .pi_msb(pi_msb), .pi_low(pi_low), .pi_end(pi_end),
        .busy(busy4), .so_data(so_data4), .so_valid(so_valid4), .pixel_wr(wr4),
        .pixel_addr(addr4), .pixel_dataout(dout4),
        .pixel_finish(fin4), .pixel_overflow(ov4));

    always #5 clk = ~clk;

    int          nbits, nwr, addr_bad, sd_bad, zrun, zmax, nwr4;
    logic [31:0] seq, pix;
    int          npass = 0, ntot = 0;

    always @(negedge clk) begin
        if (reset) begin
            nbits = 0; nwr = 0; addr_bad = 0; sd_bad = 0; zrun = 0; zmax = 0;
            seq = '0; pix = '0;
        end else begin
            if (so_valid) begin nbits++; seq = {seq[30:0], so_data}; end
            else if (so_data) sd_bad++;
            if (pixel_wr) begin
                if (pixel_addr != nwr[7:0]) addr_bad++;
                nwr++;
                pix = {pix[23:0], pixel_dataout};
            end
            if (pixel_wr && pixel_dataout == 8'h00) zrun++; else zrun = 0;
            if (zrun > zmax) zmax = zrun;
        end
        if (r4) nwr4 = 0;
        else if (wr4) nwr4++;
    end

    task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
        ntot++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    endtask

    task automatic do_reset();
        reset = 1;
        repeat (2) @(negedge clk);
        reset = 0;
    endtask

    task automatic do_load(input logic [15:0] d, input logic [1:0] len,
                           input logic fl, input logic ms, input logic lo);
        pi_data = d; pi_length = len; pi_fill = fl; pi_msb = ms; pi_low = lo; load = 1;
        @(negedge clk);
        load = 0;
    endtask

    task automatic wait_idle(input bit which, input string nm);
        for (int i = 0; i < 200; i++) begin
            if ((which ? busy4 : busy) == 1'b0) break;
            @(negedge clk);
        end
        check(nm, which ? busy4 : busy, 0);
        repeat (2) @(negedge clk);
    endtask

    typedef struct {
        logic [15:0] d; logic [1:0] len; logic fl, ms, lo;
        int nb; logic [31:0] sq; int np; logic [31:0] px;
    } vec_t;
    vec_t vt[7];

    initial begin
        vt[0] = '{16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b1,  8, 32'h0000_00C3, 1, 32'h0000_00C3};
        vt[1] = '{16'h8001, 2'd1, 1'b0, 1'b0, 1'b0, 16, 32'h0000_8001, 2, 32'h0000_8001};
        vt[2] = '{16'h1234, 2'd3, 1'b1, 1'b1, 1'b0, 32, 32'h1234_0000, 4, 32'h1234_0000};
        vt[3] = '{16'h1234, 2'd3, 1'b0, 1'b1, 1'b0, 32, 32'h0000_1234, 4, 32'h0000_1234};
        vt[4] = '{16'hA5C3, 2'd0, 1'b0, 1'b1, 1'b0,  8, 32'h0000_00A5, 1, 32'h0000_00A5};
        vt[5] = '{16'h1E35, 2'd0, 1'b0, 1'b0, 1'b1,  8, 32'h0000_00AC, 1, 32'h0000_00AC};
        vt[6] = '{16'h1234, 2'd2, 1'b1, 1'b0, 1'b0, 24, 32'h0000_2C48, 3, 32'h0000_2C48};

        repeat (2) @(negedge clk);
        check("reset_outputs", {busy, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout,
                                pixel_finish, pixel_overflow}, 0);
        reset = 0;

        for (int i = 0; i < 7; i++) begin
            do_reset();
            do_load(vt[i].d, vt[i].len, vt[i].fl, vt[i].ms, vt[i].lo);
            wait_idle(0, $sformatf("v%0d_idle", i));
            check($sformatf("v%0d_nbits", i), nbits, vt[i].nb);
            check($sformatf("v%0d_seq", i), seq, vt[i].sq);
            check($sformatf("v%0d_nwr", i), nwr, vt[i].np);
            check($sformatf("v%0d_pix", i), pix, vt[i].px);
            check($sformatf("v%0d_addr", i), {addr_bad, sd_bad}, 0);
        end

        // load pulse while busy is ignored
        do_reset();
        do_load(16'h00C3, 2'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        do_load(16'hFFFF, 2'd3, 1'b0, 1'b0, 1'b0);
        wait_idle(0, "busy_idle");
        repeat (12) @(negedge clk);
        check("busy_nbits", nbits, 8);
        check("busy_nwr", nwr, 1);
        check("busy_pix", pix[7:0], 8'hC3);
        check("busy_addr", pixel_addr, 8'd1);

        // three words, end during the third, then zero fill to the top
        do_reset();
        do_load(16'h0011, 2'd0, 1'b0, 1'b1, 1'b1);
        wait_idle(0, "end_w1");
        do_load(16'h0022, 2'd0, 1'b0, 1'b1, 1'b1);
        wait_idle(0, "end_w2");
        do_load(16'h0033, 2'd0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        pi_end = 1;
        @(negedge clk);
        pi_end = 0;
        for (int i = 0; i < 400; i++) begin
            if (pixel_finish) break;
            @(negedge clk);
        end
        check("fill_finish", pixel_finish, 1);
        repeat (5) @(negedge clk);
        do_load(16'h00FF, 2'd0, 1'b0, 1'b1, 1'b1);
        repeat (12) @(negedge clk);
        check("fill_nwr", nwr, 256);
        check("fill_zrun", zmax, 253);
        check("fill_addr", addr_bad, 0);
        check("fill_busy", {busy, pixel_finish}, 2'b11);
        check("fill_nbits", nbits, 24);

        // mid-word reset discards the partial pixel
        do_reset();
        do_load(16'hFFFF, 2'd1, 1'b0, 1'b1, 1'b0);
        repeat (5) @(negedge clk);
        reset = 1;
        @(negedge clk);
        check("rst_outputs", {busy, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout,
                              pixel_finish, pixel_overflow}, 0);
        reset = 0;
        repeat (10) @(negedge clk);
        check("rst_quiet", {nwr, nbits}, 0);
        do_load(16'h005A, 2'd0, 1'b0, 1'b1, 1'b1);
        wait_idle(0, "rst_idle");
        check("rst_nwr", nwr, 1);
        check("rst_pix", pix[7:0], 8'h5A);
        check("rst_addr", addr_bad, 0);

        // depth-4 memory: overflow on the fifth word
        r4 = 1;
        repeat (2) @(negedge clk);
        r4 = 0;
        for (int w = 0; w < 6; w++) begin
            do_load(16'h0040 + 16'(w), 2'd0, 1'b0, 1'b1, 1'b1);
            wait_idle(1, $sformatf("ov_idle%0d", w));
            if (w == 3) check("ov_after4", {nwr4, 31'd0, ov4}, {32'd4, 32'd0});
            if (w == 4) check("ov_after5", {nwr4, 29'd0, addr4, ov4}, {32'd4, 29'd0, 2'd3, 1'b1});
        end
        check("ov_after6", {nwr4, 30'd0, addr4}, {32'd4, 30'd0, 2'd3});
        pi_end = 1;
        @(negedge clk);
        pi_end = 0;
        for (int i = 0; i < 20; i++) begin
            if (fin4) break;
            @(negedge clk);
        end
        check("ov_finish", {fin4, busy4}, 2'b11);
        check("ov_nofill", nwr4, 4);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end
endmodule

// File: doc/sti_dac_gen.md
STI_DAC_GEN -- requirements
Module: sti_dac_gen

Interface
REQ-001 Parameters SHALL be: DATA_W, default 16, parallel word width; LEN_W, default 2, length-code width; PIX_W, default 8, pixel and length-unit width; PIX_DEPTH, default 256, pixel memory depth (power of 2, at least 2); AW = clog2(PIX_DEPTH).
REQ-002 The block SHALL have one clock; reset is synchronous and active-high.
REQ-003 Ports SHALL be as follows, clock and reset first:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous active-high reset
- load  in  1  parallel word strobe
- pi_data  in  DATA_W  parallel word
- pi_length  in  LEN_W  serial length L = PIX_W*(pi_length+1) bits
- pi_fill  in  1  padding placement when L > DATA_W
- pi_msb  in  1  1 = MSB-first, 0 = LSB-first
- pi_low  in  1  segment select when L < DATA_W
- pi_end  in  1  last word indication (level)
- busy  out  1  word being serialised, or fill/done in progress
- so_data  out  1  serial bit
- so_valid  out  1  so_data qualifier
- pixel_wr  out  1  one-cycle pixel write strobe
- pixel_addr  out  AW  pixel write address
- pixel_dataout  out  PIX_W  pixel write data
- pixel_finish  out  1  memory complete (sticky)
- pixel_overflow  out  1  data lost because memory was full (sticky)

Function
REQ-004 The block SHALL sample load only in IDLE; a load in any other state SHALL be ignored with no side effect.
REQ-005 An accepted load SHALL latch pi_data, pi_length, pi_fill, pi_msb and pi_low, then enter SHIFT.
REQ-006 The L-bit frame F SHALL be built according to L:
- L == DATA_W: F = pi_data.
- L < DATA_W: F = pi_data[L-1:0] when pi_low=1, else pi_data[DATA_W-1:DATA_W-L].
- L > DATA_W: zero-extend pi_data. pi_fill=1 places the data in the MSBs with zeros below; pi_fill=0 places the data in the LSBs with zeros above.
REQ-007 In SHIFT, so_valid SHALL be 1 for exactly L consecutive cycles, starting the cycle after load is accepted.
- One bit of F is presented per cycle: F[L-1] first when pi_msb=1, F[0] first otherwise.
REQ-008 When so_valid=0, so_data SHALL be 0.
REQ-009 After the last bit, the block SHALL return to IDLE the next cycle.
- busy SHALL be 1 in SHIFT, FILL and DONE, and 0 in IDLE.
REQ-010 Serial bits SHALL be packed into pixels in transmission order, with the first bit of each group of PIX_W becoming pixel bit PIX_W-1.
REQ-011 A pixel write SHALL occur the cycle after the so_valid cycle that carries the pixel's last bit.
- pixel_wr is high for one cycle, with pixel_addr and pixel_dataout valid in that same cycle.
- pixel_addr then increments by 1.
REQ-012 After a write to address PIX_DEPTH-1, the memory SHALL be full.
- Further pixels are serialised on so_data but not written (pixel_wr stays 0).
- pixel_overflow is set to 1.
- pixel_addr holds PIX_DEPTH-1 with no wrap.
REQ-013 When pi_end=1 in any cycle from the load-accept cycle onward, an end flag SHALL be latched.
- pi_end and load in the same cycle: the load is accepted and the end flag is latched.
REQ-014 With the end flag set, entry to FILL SHALL happen as follows:
- SHIFT with the end flag set goes to FILL after the final pixel write instead of to IDLE.
- The end flag seen in IDLE goes to FILL the next cycle.
REQ-015 In FILL, the block SHALL write 0 to every remaining address, one per cycle, ascending to PIX_DEPTH-1.
- When the memory is already full, FILL writes nothing.
REQ-016 The cycle after FILL completes, the block SHALL enter DONE with pixel_finish=1.
- DONE is left only by reset.
REQ-017 Widths:
- Bit counter: LEN_W + clog2(PIX_W) + 1 bits.
- L > PIX_W*2^LEN_W is impossible by construction.
- No arithmetic overflow is permitted in the address path.

Reset
REQ-018 While reset=1 at a clock edge, every output SHALL be 0 and the next state SHALL be IDLE.
- Outputs: busy, so_data, so_valid, pixel_wr, pixel_addr, pixel_dataout, pixel_finish, pixel_overflow.
- The end flag, bit counter and pixel shift register are cleared.
REQ-019 Reset asserted mid-SHIFT or mid-FILL SHALL abort the operation immediately.
- The partially packed pixel is discarded and not written.

Verification (defaults unless stated)
REQ-020 Load 16'hA5C3, length=0, low=1, msb=1 -> so_data 1,1,0,0,0,0,1,1 over 8 cycles; pixel_wr at addr 0 with data 8'hC3.
REQ-021 Load 16'h8001, length=1, msb=0 -> so_data 1, fourteen 0s, 1; writes 8'h80 at addr 0 and 8'h01 at addr 1.
REQ-022 Load 16'h1234, length=3, msb=1:
- fill=1 -> writes 12,34,00,00.
- fill=0 -> writes 00,00,12,34.
- so_valid high exactly 32 cycles.
REQ-023 Second load pulse while busy=1 -> ignored; so_valid count and pixel_addr unchanged.
REQ-024 Three 8-bit words, pi_end raised during the third -> zero writes at addrs 3..255 on 253 consecutive cycles, then pixel_finish=1 and busy stays 1.
REQ-025 PIX_DEPTH=4, six 8-bit words -> addrs 0..3 written, pixel_overflow=1 after the fifth word, no further pixel_wr.
REQ-026 Reset asserted at bit 5 of a 16-bit word -> next cycle all outputs 0; a subsequent load writes from addr 0.
